// File: rtl/fifo_read_prefetch_ctrl.sv
// Read-side controller for the async FIFO core: credit-based rinc, prefetch buffer with
// valid/ready output, streaming and fixed-length burst modes, saturating starved-cycle counter.
module fifo_read_prefetch_ctrl #(
    parameter int DSIZE  = 8,
    parameter int PDEPTH = 2,
    parameter int CNTW   = 8
) (
    input  logic                    rclk,
    input  logic                    rrst,
    input  logic                    rempty,
    input  logic [DSIZE-1:0]        rdata,
    output logic                    rinc,
    input  logic                    mode,
    input  logic [CNTW-1:0]         burst_len,
    input  logic                    burst_start,
    output logic                    burst_busy,
    output logic                    burst_done,
    output logic [DSIZE-1:0]        dout,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic [$clog2(PDEPTH):0] pf_count,
    output logic [CNTW-1:0]         stall_cnt,
    output logic [1:0]              fsm_state
);

    // Output handshake: a word moves to the consumer on every rclk edge where
    // dout_valid && dout_ready; dout is held while dout_valid && !dout_ready.

    localparam int AW = $clog2(PDEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW:0] DEPTH_V = (PW + 1)'(PDEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]       state;
    logic             active_mode;
    logic             inflight;
    logic [CNTW-1:0]  remaining;
    logic [DSIZE-1:0] buf_mem [PDEPTH];
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;

    logic             enable;
    logic             credit;
    logic             push;
    logic             pop;
    logic             drained;
    logic             stall_en;
    logic [PW:0]      occupancy;

    // Words already buffered plus the one still coming back from the core
    // must fit, so a read is only issued against free space.
    always_comb begin
        enable = 1'b0;
        case (state)
            ST_IDLE: enable = !active_mode;
            ST_RUN:  enable = (remaining != '0);
            default: enable = 1'b0;
        endcase
    end

    assign occupancy  = {1'b0, pf_count} + {{PW{1'b0}}, inflight};
    assign credit     = (occupancy < DEPTH_V);
    assign rinc       = !rrst && !rempty && credit && enable;

    assign push       = inflight;
    assign dout_valid = (pf_count != '0);
    assign pop        = dout_valid && dout_ready;
    assign dout       = buf_mem[head];

    assign burst_busy = (state == ST_RUN) || (state == ST_DRAIN);
    assign drained    = (pf_count == '0) && !inflight;
    assign stall_en   = !active_mode || burst_busy;
    assign fsm_state  = state;

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            inflight <= 1'b0;
            head     <= '0;
            tail     <= '0;
            pf_count <= '0;
            for (int i = 0; i < PDEPTH; i++) begin
                buf_mem[i] <= '0;
            end
        end else begin
            inflight <= rinc;
            if (push) begin
                buf_mem[tail] <= rdata;
                tail          <= tail + AW'(1);
            end
            if (pop) begin
                head <= head + AW'(1);
            end
            case ({push, pop})
                2'b10:   pf_count <= pf_count + 1'b1;
                2'b01:   pf_count <= pf_count - 1'b1;
                default: pf_count <= pf_count;
            endcase
        end
    end

    // Mode is sampled only in IDLE so a running burst cannot be redirected.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state       <= ST_IDLE;
            active_mode <= 1'b0;
            remaining   <= '0;
            burst_done  <= 1'b0;
        end else begin
            burst_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    active_mode <= mode;
                    if (burst_start && active_mode && (burst_len != '0)) begin
                        remaining <= burst_len;
                        state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (rinc) begin
                        remaining <= remaining - 1'b1;
                        if (remaining == CNTW'(1)) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drained) begin
                        burst_done <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            stall_cnt <= '0;
        end else if (stall_en && dout_ready && !dout_valid && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_read_prefetch_ctrl.sv
// Bench for fifo_read_prefetch_ctrl: models the FIFO core, scoreboards delivered words,
// and walks streaming, backpressure, burst, starved burst, reset and stall saturation.
module tb_fifo_read_prefetch_ctrl;

    localparam int DSIZE  = 8;
    localparam int PDEPTH = 2;
    localparam int CNTW   = 4;

    logic                    rclk = 1'b0;
    logic                    rrst = 1'b1;
    logic                    rempty;
    logic [DSIZE-1:0]        rdata = '0;
    logic                    rinc;
    logic                    mode = 1'b0;
    logic [CNTW-1:0]         burst_len = '0;
    logic                    burst_start = 1'b0;
    logic                    burst_busy;
    logic                    burst_done;
    logic [DSIZE-1:0]        dout;
    logic                    dout_valid;
    logic                    dout_ready = 1'b0;
    logic [$clog2(PDEPTH):0] pf_count;
    logic [CNTW-1:0]         stall_cnt;
    logic [1:0]              fsm_state;

    fifo_read_prefetch_ctrl #(.DSIZE(DSIZE), .PDEPTH(PDEPTH), .CNTW(CNTW)) dut (
        .rclk(rclk), .rrst(rrst), .rempty(rempty), .rdata(rdata), .rinc(rinc),
        .mode(mode), .burst_len(burst_len), .burst_start(burst_start),
        .burst_busy(burst_busy), .burst_done(burst_done), .dout(dout),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .pf_count(pf_count),
        .stall_cnt(stall_cnt), .fsm_state(fsm_state)
    );

    // clock / reset
    always #5 rclk = ~rclk;

    // FIFO core model: words written by the tasks, read on rinc, rdata one cycle later
    logic [DSIZE-1:0] fifo_mem [256];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign rempty = (rd_ptr == wr_ptr);

    // scoreboard
    logic [DSIZE-1:0] exp_q[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_rinc, n_pop, n_done;
    int first_rinc_cyc, first_valid_cyc, last_pop_cyc, done_cyc;
    logic prev_hold = 1'b0;
    logic [DSIZE-1:0] prev_dout = '0;

    task automatic clear_counts();
        n_rinc = 0; n_pop = 0; n_done = 0;
        first_rinc_cyc = -1; first_valid_cyc = -1; last_pop_cyc = -1; done_cyc = -1;
    endtask

    task automatic fifo_write(input logic [DSIZE-1:0] w);
        fifo_mem[wr_ptr] = w;
        wr_ptr++;
        exp_q.push_back(w);
    endtask

    // one clock: sample/compare at negedge, FIFO model at posedge, return 1 after the edge
    task automatic tick();
        logic rinc_s;
        logic [DSIZE-1:0] e;
        @(negedge rclk);
        cyc++;
        rinc_s = rinc;
        checks++;
        if (rinc && rempty) begin
            errors++;
            $display("FAIL rinc_while_empty: cyc=%0d rinc=%0b rempty=%0b, required rinc=0", cyc, rinc, rempty);
        end
        checks++;
        if (pf_count > PDEPTH) begin
            errors++;
            $display("FAIL overflow: cyc=%0d pf_count=%0d, required <= %0d", cyc, pf_count, PDEPTH);
        end
        if (prev_hold && !rrst) begin
            checks++;
            if (!dout_valid || dout !== prev_dout) begin
                errors++;
                $display("FAIL dout_hold: cyc=%0d dout=%h valid=%0b, required dout=%h valid=1", cyc, dout, dout_valid, prev_dout);
            end
        end
        if (rinc) begin
            n_rinc++;
            if (first_rinc_cyc < 0) first_rinc_cyc = cyc;
        end
        if (dout_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (burst_done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (dout_valid && dout_ready) begin
            n_pop++;
            last_pop_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL extra_word: cyc=%0d dout=%h, required no word", cyc, dout);
            end else begin
                e = exp_q.pop_front();
                if (dout !== e) begin
                    errors++;
                    $display("FAIL data_order: cyc=%0d dout=%h, required %h", cyc, dout, e);
                end
            end
        end
        prev_hold = dout_valid && !dout_ready && !rrst;
        prev_dout = dout;
        @(posedge rclk);
        if (rinc_s) begin
            rdata  <= fifo_mem[rd_ptr];
            rd_ptr <= rd_ptr + 1;
        end
        #1;
    endtask

    task automatic wait_done(input int budget, output bit got, output bit gap);
        got = 1'b0;
        gap = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (burst_done) begin
                got = 1'b1;
                break;
            end
            if (!burst_busy) gap = 1'b1;
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({rinc, dout, dout_valid, pf_count, burst_busy, burst_done, stall_cnt, fsm_state} !== '0) begin
            errors++;
            $display("FAIL reset_values: rinc=%0b dout=%h valid=%0b pf=%0d busy=%0b done=%0b stall=%0d fsm=%0d, required all 0",
                     rinc, dout, dout_valid, pf_count, burst_busy, burst_done, stall_cnt, fsm_state);
        end
        clear_counts();
        tick(); tick();
        rrst = 1'b0;
        tick(); tick();
        checks++;
        if ({rinc, dout_valid, pf_count, burst_busy, fsm_state} !== '0 || n_rinc != 0) begin
            errors++;
            $display("FAIL idle_after_reset: rinc=%0b valid=%0b pf=%0d busy=%0b fsm=%0d n_rinc=%0d, required all 0",
                     rinc, dout_valid, pf_count, burst_busy, fsm_state, n_rinc);
        end
    endtask

    task automatic test_stream();
        mode = 1'b0;
        dout_ready = 1'b1;
        clear_counts();
        for (int i = 0; i < 5; i++) fifo_write(8'h11 + 8'(i));
        repeat (20) tick();
        checks++;
        if (n_rinc != 5 || n_pop != 5) begin
            errors++;
            $display("FAIL stream_counts: rinc=%0d pops=%0d, required 5 and 5", n_rinc, n_pop);
        end
        checks++;
        if (first_valid_cyc - first_rinc_cyc != 2) begin
            errors++;
            $display("FAIL stream_latency: rinc->valid=%0d cycles, required 2", first_valid_cyc - first_rinc_cyc);
        end
        checks++;
        if (dout_valid !== 1'b0 || rinc !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stream_end: valid=%0b rinc=%0b pending=%0d, required 0 0 0", dout_valid, rinc, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        dout_ready = 1'b0;
        clear_counts();
        for (int i = 0; i < 6; i++) fifo_write(8'h21 + 8'(i));
        repeat (10) tick();
        checks++;
        if (pf_count != 2 || n_rinc != 2) begin
            errors++;
            $display("FAIL bp_credit: pf=%0d rinc=%0d, required 2 and 2", pf_count, n_rinc);
        end
        checks++;
        if (dout !== 8'h21 || dout_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_head: dout=%h valid=%0b, required 21 1", dout, dout_valid);
        end
        dout_ready = 1'b1;
        repeat (30) tick();
        checks++;
        if (n_pop != 6 || n_rinc != 6 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_release: pops=%0d rinc=%0d pending=%0d, required 6 6 0", n_pop, n_rinc, exp_q.size());
        end
    endtask

    task automatic test_burst();
        bit got, gap;
        mode = 1'b1;
        tick();
        clear_counts();
        for (int i = 0; i < 5; i++) fifo_write(8'h31 + 8'(i));
        repeat (3) tick();
        checks++;
        if (n_rinc != 0) begin
            errors++;
            $display("FAIL burst_idle_reads: rinc=%0d, required 0", n_rinc);
        end
        burst_len = 4'd3;
        burst_start = 1'b1;
        tick();
        burst_start = 1'b0;
        checks++;
        if (burst_busy !== 1'b1 || fsm_state !== 2'd1) begin
            errors++;
            $display("FAIL burst_enter: busy=%0b fsm=%0d, required 1 1", burst_busy, fsm_state);
        end
        wait_done(40, got, gap);
        checks++;
        if (!got || gap) begin
            errors++;
            $display("FAIL burst_done_seen: done=%0b busy_gap=%0b, required 1 0", got, gap);
        end
        repeat (6) tick();
        checks++;
        if (n_rinc != 3 || n_pop != 3 || n_done != 1 || (wr_ptr - rd_ptr) != 2) begin
            errors++;
            $display("FAIL burst_counts: rinc=%0d pops=%0d done=%0d left=%0d, required 3 3 1 2",
                     n_rinc, n_pop, n_done, wr_ptr - rd_ptr);
        end
        checks++;
        if (done_cyc <= last_pop_cyc || burst_busy !== 1'b0) begin
            errors++;
            $display("FAIL burst_done_order: done_cyc=%0d last_pop=%0d busy=%0b, required done after pop, busy 0",
                     done_cyc, last_pop_cyc, burst_busy);
        end
    endtask

    task automatic test_burst_starve();
        bit got, gap;
        clear_counts();
        burst_len = 4'd4;
        burst_start = 1'b1;
        tick();
        burst_start = 1'b0;
        repeat (10) tick();
        checks++;
        if (n_rinc != 2 || fsm_state !== 2'd1 || n_done != 0) begin
            errors++;
            $display("FAIL starve_wait: rinc=%0d fsm=%0d done=%0d, required 2 1 0", n_rinc, fsm_state, n_done);
        end
        burst_len = 4'd5;
        burst_start = 1'b1;
        tick();
        burst_start = 1'b0;
        for (int i = 0; i < 3; i++) fifo_write(8'h41 + 8'(i));
        wait_done(40, got, gap);
        checks++;
        if (!got || gap) begin
            errors++;
            $display("FAIL starve_done: done=%0b busy_gap=%0b, required 1 0", got, gap);
        end
        repeat (10) tick();
        burst_len = 4'd0;
        burst_start = 1'b1;
        tick();
        burst_start = 1'b0;
        repeat (3) tick();
        checks++;
        if (n_rinc != 4 || n_pop != 4 || n_done != 1 || (wr_ptr - rd_ptr) != 1) begin
            errors++;
            $display("FAIL starve_counts: rinc=%0d pops=%0d done=%0d left=%0d, required 4 4 1 1",
                     n_rinc, n_pop, n_done, wr_ptr - rd_ptr);
        end
        checks++;
        if (fsm_state !== 2'd0 || burst_busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_len_ignored: fsm=%0d busy=%0b, required 0 0", fsm_state, burst_busy);
        end
    endtask

    task automatic test_reset_mid_burst();
        bit got, gap;
        for (int i = 0; i < 4; i++) fifo_write(8'h51 + 8'(i));
        dout_ready = 1'b0;
        clear_counts();
        burst_len = 4'd4;
        burst_start = 1'b1;
        tick();
        burst_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (n_rinc == 2) break;
        end
        checks++;
        if (n_rinc != 2 || pf_count != 1 || fsm_state !== 2'd1) begin
            errors++;
            $display("FAIL pre_reset_state: rinc=%0d pf=%0d fsm=%0d, required 2 1 1", n_rinc, pf_count, fsm_state);
        end
        rrst = 1'b1;
        mode = 1'b0;
        #1;
        checks++;
        if ({rinc, dout, dout_valid, pf_count, burst_busy, burst_done, stall_cnt, fsm_state} !== '0) begin
            errors++;
            $display("FAIL mid_reset_values: rinc=%0b dout=%h valid=%0b pf=%0d busy=%0b done=%0b stall=%0d fsm=%0d, required all 0",
                     rinc, dout, dout_valid, pf_count, burst_busy, burst_done, stall_cnt, fsm_state);
        end
        repeat (3) tick();
        checks++;
        if (n_done != 0 || n_rinc != 2) begin
            errors++;
            $display("FAIL reset_no_done: done=%0d rinc=%0d, required 0 2", n_done, n_rinc);
        end
        while (exp_q.size() > wr_ptr - rd_ptr) void'(exp_q.pop_front());
        rrst = 1'b0;
        dout_ready = 1'b1;
        repeat (20) tick();
        checks++;
        if (n_pop != 3 || exp_q.size() != 0 || n_done != 0) begin
            errors++;
            $display("FAIL post_reset_drain: pops=%0d pending=%0d done=%0d, required 3 0 0", n_pop, exp_q.size(), n_done);
        end
        mode = 1'b1;
        tick();
        clear_counts();
        fifo_write(8'h61);
        fifo_write(8'h62);
        burst_len = 4'd2;
        burst_start = 1'b1;
        tick();
        burst_start = 1'b0;
        wait_done(40, got, gap);
        tick();
        checks++;
        if (!got || gap || n_rinc != 2 || n_pop != 2 || n_done != 1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL post_reset_burst: done=%0b gap=%0b rinc=%0d pops=%0d ndone=%0d pending=%0d, required 1 0 2 2 1 0",
                     got, gap, n_rinc, n_pop, n_done, exp_q.size());
        end
    endtask

    task automatic test_stall_sat();
        mode = 1'b0;
        dout_ready = 1'b1;
        rrst = 1'b1;
        tick();
        checks++;
        if (stall_cnt !== 4'd0) begin
            errors++;
            $display("FAIL stall_reset: stall_cnt=%0d, required 0", stall_cnt);
        end
        rrst = 1'b0;
        repeat (5) tick();
        checks++;
        if (stall_cnt !== 4'd5) begin
            errors++;
            $display("FAIL stall_count: stall_cnt=%0d, required 5", stall_cnt);
        end
        repeat (15) tick();
        checks++;
        if (stall_cnt !== 4'd15) begin
            errors++;
            $display("FAIL stall_saturate: stall_cnt=%0d, required 15", stall_cnt);
        end
        repeat (5) tick();
        checks++;
        if (stall_cnt !== 4'd15) begin
            errors++;
            $display("FAIL stall_hold: stall_cnt=%0d, required 15", stall_cnt);
        end
    endtask

    initial begin
        clear_counts();
        test_reset();
        test_stream();
        test_backpressure();
        test_burst();
        test_burst_starve();
        test_reset_mid_burst();
        test_stall_sat();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time=%0t, required finish before 100000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
